seq_stage_ctrl: RTL and testbench
=================================

SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 start  in  1  one-cycle pulse; begins execution at start_pc; honoured only in IDLE.
REQ-004 start_pc  in  64  initial program counter.
REQ-005 icode  in  4  fetched instruction code; valid during DECODE..PCUPD.
REQ-006 instr_valid  in  1  fetch decoded a legal instruction; sampled last cycle of FETCH.
REQ-007 imem_error  in  1  fetch address invalid; sampled last cycle of FETCH.
REQ-008 mem_ready  in  1  data-memory handshake; access completes in the cycle it is high.
REQ-009 dmem_error  in  1  data-memory fault; qualified by mem_ready.
REQ-010 pc_next  in  64  next PC from the pc_update datapath.
REQ-011 pc  out  64  architectural PC register.
REQ-012 fetch_en, decode_en, execute_en, memory_en, wb_en  out  1 each  one-hot stage enables.
REQ-013 cc_we  out  1  condition-code write strobe.
REQ-014 stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-015 halted  out  1  high in HALT.
REQ-016 instr_count  out  32  count of retired instructions.

Function
REQ-017 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; one per cycle unless stated.
REQ-018 IDLE: start=1 -> pc<=start_pc, stat<=AOK, next FETCH; else stay.
REQ-019 FETCH (1 cycle), priority: imem_error -> stat ADR, HALT; else !instr_valid -> stat INS, HALT; else icode==0 -> stat HLT, HALT; else DECODE.
REQ-020 pc does not change on any FETCH-exit to HALT.
REQ-021 DECODE -> EXECUTE; EXECUTE -> MEMORY; cc_we=1 only in EXECUTE with icode==6 (OPq).
REQ-022 MEMORY: icode in {4,5,8,9,A,B} is memory class; memory_en held high until mem_ready=1, unbounded wait.
REQ-023 MEMORY, memory class, mem_ready=1 and dmem_error=1 -> stat ADR, HALT, no WRITEBACK, pc unchanged.
REQ-024 MEMORY, memory class, mem_ready=1 and dmem_error=0 -> WRITEBACK.
REQ-025 MEMORY, non-memory class: exactly 1 cycle, mem_ready/dmem_error ignored, -> WRITEBACK.
REQ-026 WRITEBACK -> PCUPD; PCUPD: pc<=pc_next, instr_count+1, -> FETCH.
REQ-027 Non-memory instruction latency: 6 cycles FETCH to next FETCH; memory class: 5 + cycles in MEMORY.
REQ-028 instr_count wraps 0xFFFFFFFF -> 0.
REQ-029 Stage enables high only in their state; all enables and cc_we low in IDLE, PCUPD, HALT.
REQ-030 HALT is absorbing: start ignored; exit only by reset; stat, pc, instr_count frozen.
REQ-031 start outside IDLE ignored, including during MEMORY wait.

Reset
REQ-032 rst_n=0 at rising edge: state IDLE, pc=0, stat=AOK(1), instr_count=0, halted=0, all enables and cc_we 0.
REQ-033 Reset wins over all events, in any state including a MEMORY wait; aborted instruction not counted.

Structure
REQ-034 Package seq_pkg: icode constants (HALT=0 .. POPQ=B), stat codes, state enum.
REQ-035 Sub-module seq_icode_class: combinational icode -> is_mem, is_opq.
REQ-036 Registered outputs only; no combinational input-to-output paths except through state.

Verification
REQ-037 Reset, start=1 start_pc=0x100, icode=6 valid, mem_ready=0 -> cc_we for 1 cycle, pc=pc_next=0x102 after 6 cycles, instr_count=1.
REQ-038 icode=5, mem_ready low 3 MEMORY cycles then high, dmem_error=0 -> memory_en high 4 cycles, 9-cycle instruction, count+1.
REQ-039 icode=A, mem_ready=1 with dmem_error=1 -> stat=3, halted=1, wb_en never asserted, pc unchanged, count unchanged.
REQ-040 FETCH with imem_error=1 and instr_valid=0 -> stat=3 (ADR has priority), HALT; with imem_error=0, instr_valid=0 -> stat=4.
REQ-041 icode=0 -> stat=2, halted=1, pc unchanged; later start pulse -> no change.
REQ-042 rst_n=0 mid MEMORY wait -> next cycle IDLE, pc=0, stat=1, count=0; instr_count preloaded 0xFFFFFFFF + one retire -> 0.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared icode, status and FSM state encodings for the sequential stage controller
package seq_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_DECODE    = 3'd2;
  localparam state_t ST_EXECUTE   = 3'd3;
  localparam state_t ST_MEMORY    = 3'd4;
  localparam state_t ST_WRITEBACK = 3'd5;
  localparam state_t ST_PCUPD     = 3'd6;
  localparam state_t ST_HALT      = 3'd7;
endpackage

// File: rtl/seq_stage_ctrl_if.sv
// seq_stage_ctrl_if: fetch/memory handshake inputs and architectural status outputs of the controller
interface seq_stage_ctrl_if;
  logic        start;
  logic [63:0] start_pc;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        mem_ready;
  logic        dmem_error;
  logic [63:0] pc_next;
  logic [63:0] pc;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        memory_en;
  logic        wb_en;
  logic        cc_we;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] instr_count;
  modport master (
    output start, start_pc, icode, instr_valid, imem_error, mem_ready, dmem_error, pc_next,
    input  pc, fetch_en, decode_en, execute_en, memory_en, wb_en, cc_we, stat, halted, instr_count
  );
  modport slave (
    input  start, start_pc, icode, instr_valid, imem_error, mem_ready, dmem_error, pc_next,
    output pc, fetch_en, decode_en, execute_en, memory_en, wb_en, cc_we, stat, halted, instr_count
  );
endinterface

// File: rtl/seq_icode_class.sv
// seq_icode_class: classifies an icode as data-memory access and/or condition-code writer
module seq_icode_class
  import seq_pkg::*;
(
  input  logic [3:0] icode,
  output logic       is_mem,
  output logic       is_opq
);
  assign is_mem = icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  assign is_opq = icode == I_OPQ;
endmodule

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle sequential processor stage sequencer with PC, status and retire counter
module seq_stage_ctrl
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  seq_stage_ctrl_if.slave  bus
);
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        cc_we_q, cc_we_d;
  logic        is_mem, is_opq;

  seq_icode_class u_class (
    .icode  (bus.icode),
    .is_mem (is_mem),
    .is_opq (is_opq)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    stat_d        = stat_q;
    instr_count_d = instr_count_q;
    cc_we_d       = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        pc_d    = bus.start_pc;
        stat_d  = STAT_AOK;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = (bus.imem_error || !bus.instr_valid || bus.icode == I_HALT) ? ST_HALT : ST_DECODE;
        stat_d  = bus.imem_error ? STAT_ADR : !bus.instr_valid ? STAT_INS :
                  (bus.icode == I_HALT) ? STAT_HLT : stat_q;
      end
      // cc_we is registered, so it is decided one cycle early to land exactly on EXECUTE
      ST_DECODE: begin
        state_d = ST_EXECUTE;
        cc_we_d = is_opq;
      end
      ST_EXECUTE: state_d = ST_MEMORY;
      ST_MEMORY: begin
        if (!is_mem)
          state_d = ST_WRITEBACK;
        else if (bus.mem_ready) begin
          state_d = bus.dmem_error ? ST_HALT : ST_WRITEBACK;
          stat_d  = bus.dmem_error ? STAT_ADR : stat_q;
        end
      end
      ST_WRITEBACK: state_d = ST_PCUPD;
      ST_PCUPD: begin
        pc_d          = bus.pc_next;
        instr_count_d = instr_count_q + 32'd1;
        state_d       = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      stat_q        <= STAT_AOK;
      instr_count_q <= '0;
      cc_we_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      stat_q        <= stat_d;
      instr_count_q <= instr_count_d;
      cc_we_q       <= cc_we_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.stat        = stat_q;
  assign bus.instr_count = instr_count_q;
  assign bus.cc_we       = cc_we_q;
  assign bus.fetch_en    = state_q == ST_FETCH;
  assign bus.decode_en   = state_q == ST_DECODE;
  assign bus.execute_en  = state_q == ST_EXECUTE;
  assign bus.memory_en   = state_q == ST_MEMORY;
  assign bus.wb_en       = state_q == ST_WRITEBACK;
  assign bus.halted      = state_q == ST_HALT;
endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl: directed self-checking bench for seq_stage_ctrl
module tb_seq_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [4:0] en;

  seq_stage_ctrl_if bus ();
  seq_stage_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  assign en = {bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en, bus.wb_en};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [63:0] spc);
    bus.start_pc = spc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_instr(input int mem_wait, input bit poke_start,
                           output int cyc, output int n_cc, output int n_mem, output int n_wb);
    cyc = 0; n_cc = 0; n_mem = 0; n_wb = 0;
    bus.mem_ready = 1'b0;
    do begin
      tick();
      cyc++;
      n_cc += int'(bus.cc_we);
      n_wb += int'(bus.wb_en);
      if (bus.memory_en) begin
        n_mem++;
        bus.mem_ready = n_mem > mem_wait;
        bus.start = poke_start;
      end else begin
        bus.mem_ready = 1'b0;
        bus.start = 1'b0;
      end
    end while (!bus.fetch_en && !bus.halted && cyc < 40);
    bus.mem_ready = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (bus.pc !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.pc); end
    total++; if (bus.stat !== 3'd1) begin bad++; $display("FAIL reset_stat got=%0d exp=1", bus.stat); end
    total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.instr_count); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    total++; if ({en, bus.cc_we} !== 6'b0) begin bad++; $display("FAIL reset_en got=%b exp=000000", {en, bus.cc_we}); end
    rst_n = 1'b1;
    tick();
    total++; if (en !== 5'b0) begin bad++; $display("FAIL idle_hold got=%b exp=00000", en); end
  endtask

  task automatic test_opq;
    int cyc, n_cc, n_mem, n_wb;
    bus.icode = 4'h6; bus.instr_valid = 1'b1; bus.pc_next = 64'h102;
    do_start(64'h100);
    total++; if (en !== 5'b10000) begin bad++; $display("FAIL opq_fetch got=%b exp=10000", en); end
    total++; if (bus.pc !== 64'h100) begin bad++; $display("FAIL opq_start_pc got=%h exp=100", bus.pc); end
    run_instr(1000, 1'b0, cyc, n_cc, n_mem, n_wb);
    total++; if (cyc !== 6) begin bad++; $display("FAIL opq_latency got=%0d exp=6", cyc); end
    total++; if (n_cc !== 1) begin bad++; $display("FAIL opq_cc_we got=%0d exp=1", n_cc); end
    total++; if (n_mem !== 1) begin bad++; $display("FAIL opq_mem_cycles got=%0d exp=1", n_mem); end
    total++; if (bus.pc !== 64'h102) begin bad++; $display("FAIL opq_pc got=%h exp=102", bus.pc); end
    total++; if (bus.instr_count !== 32'd1) begin bad++; $display("FAIL opq_count got=%0d exp=1", bus.instr_count); end
  endtask

  task automatic test_mem_wait;
    int cyc, n_cc, n_mem, n_wb;
    bus.icode = 4'h5; bus.pc_next = 64'h10c;
    run_instr(3, 1'b1, cyc, n_cc, n_mem, n_wb);
    total++; if (n_mem !== 4) begin bad++; $display("FAIL memwait_mem_cycles got=%0d exp=4", n_mem); end
    total++; if (cyc !== 9) begin bad++; $display("FAIL memwait_latency got=%0d exp=9", cyc); end
    total++; if (n_cc !== 0) begin bad++; $display("FAIL memwait_cc_we got=%0d exp=0", n_cc); end
    total++; if (n_wb !== 1) begin bad++; $display("FAIL memwait_wb got=%0d exp=1", n_wb); end
    total++; if (bus.pc !== 64'h10c) begin bad++; $display("FAIL memwait_pc got=%h exp=10c", bus.pc); end
    total++; if (bus.instr_count !== 32'd2) begin bad++; $display("FAIL memwait_count got=%0d exp=2", bus.instr_count); end
  endtask

  task automatic test_reset_mid_mem;
    bus.icode = 4'h4; bus.mem_ready = 1'b0;
    repeat (3) tick();
    total++; if (en !== 5'b00010) begin bad++; $display("FAIL rmid_in_mem got=%b exp=00010", en); end
    repeat (2) tick();
    total++; if (en !== 5'b00010) begin bad++; $display("FAIL rmid_wait got=%b exp=00010", en); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (en !== 5'b0) begin bad++; $display("FAIL rmid_idle got=%b exp=00000", en); end
    total++; if (bus.pc !== 64'h0) begin bad++; $display("FAIL rmid_pc got=%h exp=0", bus.pc); end
    total++; if (bus.stat !== 3'd1) begin bad++; $display("FAIL rmid_stat got=%0d exp=1", bus.stat); end
    total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", bus.instr_count); end
  endtask

  task automatic test_dmem_error;
    int cyc, n_cc, n_mem, n_wb;
    bus.icode = 4'h1; bus.pc_next = 64'h110;
    do_start(64'h10c);
    run_instr(1000, 1'b0, cyc, n_cc, n_mem, n_wb);
    total++; if (cyc !== 6) begin bad++; $display("FAIL nop_latency got=%0d exp=6", cyc); end
    bus.icode = 4'hA; bus.dmem_error = 1'b1; bus.pc_next = 64'h200;
    run_instr(0, 1'b0, cyc, n_cc, n_mem, n_wb);
    bus.dmem_error = 1'b0;
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL dmem_halted got=%b exp=1", bus.halted); end
    total++; if (bus.stat !== 3'd3) begin bad++; $display("FAIL dmem_stat got=%0d exp=3", bus.stat); end
    total++; if (cyc !== 4) begin bad++; $display("FAIL dmem_latency got=%0d exp=4", cyc); end
    total++; if (n_wb !== 0) begin bad++; $display("FAIL dmem_wb got=%0d exp=0", n_wb); end
    total++; if (bus.pc !== 64'h110) begin bad++; $display("FAIL dmem_pc got=%h exp=110", bus.pc); end
    total++; if (bus.instr_count !== 32'd1) begin bad++; $display("FAIL dmem_count got=%0d exp=1", bus.instr_count); end
    total++; if ({en, bus.cc_we} !== 6'b0) begin bad++; $display("FAIL dmem_en got=%b exp=000000", {en, bus.cc_we}); end
    do_start(64'h300);
    tick();
    total++; if (bus.halted !== 1'b1 || bus.pc !== 64'h110) begin bad++; $display("FAIL dmem_absorb got=halted %b pc %h exp=halted 1 pc 110", bus.halted, bus.pc); end
  endtask

  task automatic test_fetch_faults;
    do_reset();
    bus.imem_error = 1'b1; bus.instr_valid = 1'b0;
    do_start(64'h40);
    tick();
    total++; if (bus.stat !== 3'd3) begin bad++; $display("FAIL ifault_adr_stat got=%0d exp=3", bus.stat); end
    total++; if (bus.halted !== 1'b1 || bus.pc !== 64'h40) begin bad++; $display("FAIL ifault_adr_halt got=halted %b pc %h exp=halted 1 pc 40", bus.halted, bus.pc); end
    do_reset();
    bus.imem_error = 1'b0;
    do_start(64'h80);
    tick();
    total++; if (bus.stat !== 3'd4) begin bad++; $display("FAIL ifault_ins_stat got=%0d exp=4", bus.stat); end
    total++; if (bus.halted !== 1'b1 || bus.pc !== 64'h80) begin bad++; $display("FAIL ifault_ins_halt got=halted %b pc %h exp=halted 1 pc 80", bus.halted, bus.pc); end
  endtask

  task automatic test_halt_icode;
    do_reset();
    bus.instr_valid = 1'b1; bus.icode = 4'h0;
    do_start(64'h500);
    tick();
    total++; if (bus.stat !== 3'd2) begin bad++; $display("FAIL hlt_stat got=%0d exp=2", bus.stat); end
    total++; if (bus.halted !== 1'b1 || bus.pc !== 64'h500) begin bad++; $display("FAIL hlt_halt got=halted %b pc %h exp=halted 1 pc 500", bus.halted, bus.pc); end
    do_start(64'h600);
    tick();
    total++; if (bus.stat !== 3'd2 || bus.pc !== 64'h500 || bus.halted !== 1'b1) begin bad++; $display("FAIL hlt_absorb got=stat %0d pc %h halted %b exp=stat 2 pc 500 halted 1", bus.stat, bus.pc, bus.halted); end
  endtask

  task automatic test_count_wrap;
    int cyc, n_cc, n_mem, n_wb;
    do_reset();
    bus.icode = 4'h1; bus.pc_next = 64'h8;
    do_start(64'h0);
    force dut.instr_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.instr_count_q;
    total++; if (bus.instr_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffffffff", bus.instr_count); end
    run_instr(1000, 1'b0, cyc, n_cc, n_mem, n_wb);
    total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL wrap_count got=%h exp=0", bus.instr_count); end
    total++; if (bus.pc !== 64'h8 || bus.fetch_en !== 1'b1) begin bad++; $display("FAIL wrap_pc got=pc %h fetch %b exp=pc 8 fetch 1", bus.pc, bus.fetch_en); end
  endtask

  initial begin
    bus.start = 1'b0; bus.start_pc = '0; bus.icode = '0; bus.instr_valid = 1'b0;
    bus.imem_error = 1'b0; bus.mem_ready = 1'b0; bus.dmem_error = 1'b0; bus.pc_next = '0;
    test_reset();
    test_opq();
    test_mem_wait();
    test_reset_mid_mem();
    test_dmem_error();
    test_fetch_faults();
    test_halt_icode();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
